// File: rtl/voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer_pkg
// Purpose  : Shared constants, FSM state encoding and the gain-ramp helper
//            for the voice mixer and its tick generator.
// Ports    : none (package)
// Config   : ramp_toward() is only referenced when VOICE_MIXER_RAMP_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
package voice_mixer_pkg;

  localparam int SAMPLE_W = 8;
  localparam int GAIN_W   = 8;
  // gain (0..255) * centred sample (-128..127) spans -32640..32385
  localparam int PROD_W   = 17;

  localparam logic [SAMPLE_W-1:0] MIDPOINT = 8'd128;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_EMIT  = 2'd3;

  // Move cur toward tgt by at most step, never overshooting the target.
  function automatic logic [GAIN_W-1:0] ramp_toward(
    input logic [GAIN_W-1:0] cur,
    input logic [GAIN_W-1:0] tgt,
    input logic [GAIN_W-1:0] step
  );
    logic [GAIN_W-1:0] nxt;
    if (cur < tgt)
      nxt = ((tgt - cur) > step) ? (cur + step) : tgt;
    else if (cur > tgt)
      nxt = ((cur - tgt) > step) ? (cur - step) : tgt;
    else
      nxt = cur;
    return nxt;
  endfunction

endpackage : voice_mixer_pkg
`default_nettype wire

// File: rtl/mixer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : mixer_tick_gen
// Purpose  : Free-running 0..SAMPLE_PERIOD-1 counter; tick_out is high for
//            the one cycle in which the counter has just wrapped to 0.
// Ports    : clk_in   - clock
//            rst_in   - asynchronous active-high reset
//            tick_out - one-cycle sample-rate strobe
// Revision : 1.0 - initial release
// ============================================================================
module mixer_tick_gen
  import voice_mixer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 4536
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count    <= '0;
      tick_out <= 1'b0;
    end else begin
      count    <= (count == LAST) ? '0 : count + 1'b1;
      tick_out <= (count == LAST);
    end
  end

endmodule : mixer_tick_gen
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer
// Purpose  : Mixes NUM_VOICES offset-binary voices into one 8-bit PWM sample
//            per tick, one voice multiply-accumulate per cycle.
// Ports    : clk_in, rst_in (async, active-high)
//            voice_update_in / voice_valid_in / voice_velocity_in - gain load
//            voice_sample_in    - per-voice oscillator samples
//            pwm_data_out       - mixed sample (held between pulses)
//            pwm_data_ready_out - one-cycle strobe with each new sample
//            active_count_out   - voices with nonzero gain
//            clip_out           - strobe with ready when the mix saturated
//            busy_out           - high in ACCUM, SCALE and EMIT
// Config   : VOICE_MIXER_RAMP_EN - gains slew toward target by RAMP_STEP
//            per emitted sample instead of jumping on latch.
// Revision : 1.0 - initial release
// ============================================================================
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES    = 8,
  parameter int SAMPLE_PERIOD = 4536,
  parameter int ATTEN_SHIFT   = 2,
  parameter int RAMP_STEP     = 4
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     voice_update_in,
  input  logic [NUM_VOICES-1:0]                    voice_valid_in,
  input  logic [NUM_VOICES-1:0][GAIN_W-1:0]        voice_velocity_in,
  input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]      voice_sample_in,
  output logic [SAMPLE_W-1:0]                      pwm_data_out,
  output logic                                     pwm_data_ready_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]          active_count_out,
  output logic                                     clip_out,
  output logic                                     busy_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = PROD_W + $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W:0]   MID_EXT  = (ACC_W + 1)'(MIDPOINT);

  generate
    if (SAMPLE_PERIOD < NUM_VOICES + 3) begin : g_period_check
      $error("voice_mixer: SAMPLE_PERIOD must be at least NUM_VOICES+3");
    end
    if (NUM_VOICES < 2 || NUM_VOICES > 16) begin : g_voices_check
      $error("voice_mixer: NUM_VOICES must be in 2..16");
    end
    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_step_check
      $error("voice_mixer: RAMP_STEP must be in 1..255");
    end
  endgenerate

  state_t                              state;
  logic                                tick;
  logic [IDX_W-1:0]                    idx;
  logic signed [ACC_W-1:0]             acc;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] snap;
  logic [NUM_VOICES-1:0][GAIN_W-1:0]   gain;

  logic                                pend;
  logic [NUM_VOICES-1:0]               pend_valid;
  logic [NUM_VOICES-1:0][GAIN_W-1:0]   pend_vel;

  mixer_tick_gen #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick_out (tick)
  );

  assign busy_out = (state != ST_IDLE);

  // ---------------------------------------------------------------- MAC path
  logic signed [SAMPLE_W:0]             cur_diff;
  logic signed [GAIN_W:0]               cur_gain;
  logic signed [SAMPLE_W+GAIN_W+1:0]    full_prod;
  logic [PROD_W-1:0]                    cur_prod;

  always_comb begin
    cur_diff  = $signed({1'b0, snap[idx]}) - $signed({1'b0, MIDPOINT});
    cur_gain  = $signed({1'b0, gain[idx]});
    full_prod = cur_gain * cur_diff;
    cur_prod  = (gain[idx] != '0) ? full_prod[PROD_W-1:0] : '0;
  end

  // -------------------------------------------------------------- scale/sat
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W:0]   biased;
  logic                    sat_lo;
  logic                    sat_hi;
  logic [SAMPLE_W-1:0]     scaled;

  always_comb begin
    shifted = acc >>> (7 + ATTEN_SHIFT);
    biased  = $signed({shifted[ACC_W-1], shifted}) + MID_EXT;
    sat_lo  = biased[ACC_W];
    sat_hi  = !biased[ACC_W] && (|biased[ACC_W-1:SAMPLE_W]);
    scaled  = sat_lo ? '0 : (sat_hi ? '1 : biased[SAMPLE_W-1:0]);
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      idx                <= '0;
      acc                <= '0;
      snap               <= '0;
      pwm_data_out       <= MIDPOINT;
      pwm_data_ready_out <= 1'b0;
      clip_out           <= 1'b0;
    end else begin
      pwm_data_ready_out <= 1'b0;
      clip_out           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_ACCUM;
            snap  <= voice_sample_in;
            acc   <= '0;
            idx   <= '0;
          end
        end
        ST_ACCUM: begin
          acc <= acc + $signed({{(ACC_W-PROD_W){cur_prod[PROD_W-1]}}, cur_prod});
          if (idx == LAST_IDX) state <= ST_SCALE;
          else                 idx   <= idx + 1'b1;
        end
        ST_SCALE: begin
          // Output registers load as EMIT is entered so the strobe and the
          // new sample are visible during the EMIT cycle.
          pwm_data_out       <= scaled;
          pwm_data_ready_out <= 1'b1;
          clip_out           <= sat_lo | sat_hi;
          state              <= ST_EMIT;
        end
        ST_EMIT:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- gain load control
  // Gains are frozen while busy; an update seen in ACCUM/SCALE is parked and
  // applied on the EMIT edge. An update arriving in EMIT itself is newer than
  // anything parked, so it wins.
  logic                              apply_upd;
  logic [NUM_VOICES-1:0]             apply_valid;
  logic [NUM_VOICES-1:0][GAIN_W-1:0] apply_vel;

  always_comb begin
    apply_upd   = 1'b0;
    apply_valid = voice_valid_in;
    apply_vel   = voice_velocity_in;
    if (voice_update_in && (state == ST_IDLE || state == ST_EMIT)) begin
      apply_upd = 1'b1;
    end else if (state == ST_EMIT && pend) begin
      apply_upd   = 1'b1;
      apply_valid = pend_valid;
      apply_vel   = pend_vel;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend       <= 1'b0;
      pend_valid <= '0;
      pend_vel   <= '0;
    end else if (voice_update_in && (state == ST_ACCUM || state == ST_SCALE)) begin
      pend       <= 1'b1;
      pend_valid <= voice_valid_in;
      pend_vel   <= voice_velocity_in;
    end else if (state == ST_EMIT) begin
      pend <= 1'b0;
    end
  end

`ifdef VOICE_MIXER_RAMP_EN
  logic [NUM_VOICES-1:0][GAIN_W-1:0] target;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      target <= '0;
      gain   <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (apply_upd)
          target[i] <= apply_valid[i] ? apply_vel[i] : '0;
        if (state == ST_EMIT)
          gain[i] <= ramp_toward(gain[i], target[i], GAIN_W'(RAMP_STEP));
      end
    end
  end
`else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gain <= '0;
    end else if (apply_upd) begin
      for (int i = 0; i < NUM_VOICES; i++)
        gain[i] <= apply_valid[i] ? apply_vel[i] : '0;
    end
  end
`endif

  // ------------------------------------------------------------ active count
  logic [CNT_W-1:0] nz_count;

  always_comb begin
    nz_count = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      nz_count = nz_count + CNT_W'(gain[i] != '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) active_count_out <= '0;
    else        active_count_out <= nz_count;
  end

endmodule : voice_mixer
`default_nettype wire
